// File: rtl/input_ctrl_if.sv
// input_ctrl_if: the nibble-stream bus between a producer, input_ctrl and the
// 4-lane input buffer.
//   din/vin/sof : incoming nibble, valid, start-of-frame (producer -> ctrl)
//   frame_ack   : consumer has taken the held frame (consumer -> ctrl)
//   dout/cntout/enaout : registered buffer write port (ctrl -> buffer)
//   frame_rdy/busy/err : status (ctrl -> consumer)
// master = producer/consumer side, slave = input_ctrl.
interface input_ctrl_if #(
  parameter int NDATA = 128
);
  localparam int NDATA_LOG = $clog2(NDATA);

  logic [3:0]           din;
  logic                 vin;
  logic                 sof;
  logic                 frame_ack;
  logic [3:0]           dout;
  logic [NDATA_LOG-1:0] cntout;
  logic                 enaout;
  logic                 frame_rdy;
  logic                 busy;
  logic                 err;

  modport master (
    output din, vin, sof, frame_ack,
    input  dout, cntout, enaout, frame_rdy, busy, err
  );

  modport slave (
    input  din, vin, sof, frame_ack,
    output dout, cntout, enaout, frame_rdy, busy, err
  );
endinterface

// File: rtl/input_ctrl.sv
// input_ctrl: front-end sequencer for the 4-lane input buffer.
// Collects one frame of NDATA nibbles into buffer slots 0..NDATA-1, then holds
// off new data until frame_ack. Every accepted nibble appears one cycle later
// as dout/cntout with a single-cycle enaout.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : input_ctrl_if.slave (din, vin, sof, frame_ack in;
//           dout, cntout, enaout, frame_rdy, busy, err out)
// Optional feature: define INPUT_CTRL_TIMEOUT_EN to abort a frame after
// TIMEOUT consecutive idle cycles inside FILL (err pulse, back to IDLE).
module input_ctrl #(
  parameter int NDATA   = 128,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  input_ctrl_if.slave  bus
);
  localparam int NDATA_LOG = $clog2(NDATA);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // elaboration-time parameter sanity
  if (NDATA < 2 || (NDATA & (NDATA - 1)) != 0) begin : g_bad_ndata
    $error("input_ctrl: NDATA must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("input_ctrl: TIMEOUT must be >= 1");
  end

  logic [1:0]           state, state_nxt;
  logic [NDATA_LOG-1:0] cnt, cnt_nxt;
  logic                 acc;
  logic [NDATA_LOG-1:0] slot;
  logic                 err_nxt;

  logic [3:0]           dout_q;
  logic [NDATA_LOG-1:0] cntout_q;
  logic                 enaout_q;
  logic                 frame_rdy_q;
  logic                 err_q;

`ifdef INPUT_CTRL_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  logic [GAP_W-1:0] gap, gap_nxt;
  logic             gap_hit;

  // fires on the TIMEOUT-th consecutive idle cycle in FILL
  assign gap_hit = (state == FILL) && !bus.vin && (gap == GAP_W'(TIMEOUT - 1));

  always_comb begin
    gap_nxt = '0;
    if (state == FILL && !bus.vin && !gap_hit) gap_nxt = gap + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap <= '0;
    else     gap <= gap_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc       = 1'b0;
    slot      = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // data without sof is dropped silently
        if (bus.vin && bus.sof) begin
          acc       = 1'b1;
          slot      = '0;
          cnt_nxt   = NDATA_LOG'(1);
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (bus.vin) begin
          acc = 1'b1;
          if (bus.sof) begin
            // restart: abandon partial frame, flag it
            slot    = '0;
            cnt_nxt = NDATA_LOG'(1);
            err_nxt = 1'b1;
          end else begin
            slot    = cnt;
            cnt_nxt = cnt + 1'b1;  // wraps to 0 after the last slot
            if (cnt == NDATA_LOG'(NDATA - 1)) state_nxt = DONE;
          end
        end
`ifdef INPUT_CTRL_TIMEOUT_EN
        else if (gap_hit) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
`endif
      end
      DONE: begin
        if (bus.frame_ack) begin
          state_nxt = IDLE;
          // same-cycle sof opens the next frame back-to-back
          if (bus.vin && bus.sof) begin
            acc       = 1'b1;
            slot      = '0;
            cnt_nxt   = NDATA_LOG'(1);
            state_nxt = FILL;
          end else if (bus.vin) begin
            err_nxt = 1'b1;
          end
        end else if (bus.vin) begin
          err_nxt = 1'b1;  // buffer full, nibble lost
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dout_q      <= '0;
      cntout_q    <= '0;
      enaout_q    <= 1'b0;
      frame_rdy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      enaout_q    <= acc;
      err_q       <= err_nxt;
      // rises one cycle after the last enaout; ack drops it next cycle
      frame_rdy_q <= (state == DONE) && !bus.frame_ack;
      if (acc) begin
        dout_q   <= bus.din;
        cntout_q <= slot;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.cntout    = cntout_q;
  assign bus.enaout    = enaout_q;
  assign bus.frame_rdy = frame_rdy_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state == FILL);

endmodule

// File: tb/tb_input_ctrl.sv
// tb_input_ctrl: directed-vector bench for input_ctrl (NDATA=8, TIMEOUT=4).
// A queue-based frame model predicts outputs every cycle; literal checks pin
// the key scenarios.
module tb_input_ctrl;
  localparam int NDATA   = 8;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  input_ctrl_if #(.NDATA(NDATA)) bus ();

  input_ctrl #(.NDATA(NDATA), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- model ----------------
  logic [3:0] frame_q[$];   // nibbles of the frame being collected
  bit         held;         // complete frame waiting for ack
  int         idle;
  bit         e_ena, e_err, e_rdy, e_busy;
  int         e_dout, e_cnt;

  task automatic model_reset();
    frame_q.delete();
    held = 0; idle = 0;
    e_ena = 0; e_err = 0; e_rdy = 0; e_busy = 0; e_dout = 0; e_cnt = 0;
  endtask

  initial model_reset();
  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      bit acc;
      acc   = 0;
      e_ena = 0;
      e_err = 0;
      e_rdy = held && !bus.frame_ack;
      if (held) begin
        if (bus.vin && !(bus.frame_ack && bus.sof)) e_err = 1;
        if (bus.frame_ack) begin
          held = 0;
          if (bus.vin && bus.sof) acc = 1;
        end
      end else if (bus.vin) begin
        if (bus.sof) begin
          if (frame_q.size() > 0) e_err = 1;
          frame_q.delete();
          acc = 1;
        end else if (frame_q.size() > 0) acc = 1;
      end
`ifdef INPUT_CTRL_TIMEOUT_EN
      if (frame_q.size() > 0 && !bus.vin) begin
        idle++;
        if (idle == TIMEOUT) begin
          frame_q.delete();
          e_err = 1;
          idle  = 0;
        end
      end else idle = 0;
`endif
      if (acc) begin
        e_ena  = 1;
        e_dout = bus.din;
        e_cnt  = frame_q.size();
        frame_q.push_back(bus.din);
        if (frame_q.size() == NDATA) begin
          held = 1;
          frame_q.delete();
        end
      end
      e_busy = frame_q.size() > 0;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("enaout", bus.enaout, e_ena);
    chk("err", bus.err, e_err);
    chk("frame_rdy", bus.frame_rdy, e_rdy);
    chk("busy", bus.busy, e_busy);
    if (e_ena) begin
      chk("dout", bus.dout, e_dout);
      chk("cntout", bus.cntout, e_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [3:0] d, input logic v, input logic s, input logic a);
    @(negedge clk);
    #1;
    bus.din = d; bus.vin = v; bus.sof = s; bus.frame_ack = a;
  endtask

  initial begin
    bus.din = 0; bus.vin = 0; bus.sof = 0; bus.frame_ack = 0;
    repeat (2) cyc(0, 0, 0, 0);
    chk("rst_enaout", bus.enaout, 0);
    chk("rst_cntout", bus.cntout, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // normal frame: 1..8 into slots 0..7
    cyc(1, 1, 1, 0);
    for (int i = 2; i <= 8; i++) cyc(4'(i), 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("last_ena", bus.enaout, 1);
    chk("last_cnt", bus.cntout, 7);
    chk("last_dout", bus.dout, 8);
    chk("last_busy", bus.busy, 0);
    chk("last_rdy", bus.frame_rdy, 0);
    cyc(0, 0, 0, 0);
    chk("rdy_rise", bus.frame_rdy, 1);

    // hold: three dropped nibbles, then ack
    cyc(3, 1, 0, 0);
    cyc(4, 1, 0, 0);
    chk("hold_err", bus.err, 1);
    chk("hold_ena", bus.enaout, 0);
    cyc(5, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("ack_rdy", bus.frame_rdy, 0);
    chk("ack_busy", bus.busy, 0);
    cyc(7, 1, 0, 0);   // IDLE, no sof: dropped silently
    cyc(0, 0, 0, 0);
    chk("idle_drop_ena", bus.enaout, 0);
    chk("idle_drop_err", bus.err, 0);

    // second frame then back-to-back ack+sof
    cyc(0, 1, 1, 0);
    for (int i = 1; i < NDATA; i++) cyc(4'(i), 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'hA, 1, 1, 1);
    cyc(4'hB, 1, 0, 0);
    chk("b2b_ena", bus.enaout, 1);
    chk("b2b_cnt", bus.cntout, 0);
    chk("b2b_dout", bus.dout, 4'hA);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_rdy", bus.frame_rdy, 0);

    // restart: sof at slot 5
    cyc(4'hC, 1, 0, 0);
    cyc(4'hD, 1, 0, 0);
    cyc(4'hE, 1, 0, 0);
    cyc(4'hF, 1, 1, 0);
    cyc(6, 1, 0, 0);
    chk("rs_err", bus.err, 1);
    chk("rs_cnt", bus.cntout, 0);
    chk("rs_dout", bus.dout, 4'hF);
    cyc(2, 1, 0, 0);
    chk("rs_next_cnt", bus.cntout, 1);
    chk("rs_next_err", bus.err, 0);

    // async reset while slot 3 is on the output
    cyc(3, 1, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_cnt", bus.cntout, 3);
    rst = 1'b1;
    #1;
    chk("arst_ena", bus.enaout, 0);
    chk("arst_cnt", bus.cntout, 0);
    chk("arst_dout", bus.dout, 0);
    chk("arst_busy", bus.busy, 0);
    #1;
    rst = 1'b0;
    cyc(9, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("post_rst_cnt", bus.cntout, 0);
    chk("post_rst_dout", bus.dout, 1);

    // idle gap after slot 2
    cyc(4, 1, 0, 0);
    cyc(5, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
`ifdef INPUT_CTRL_TIMEOUT_EN
    chk("to_busy", bus.busy, 0);
    chk("to_err", bus.err, 1);
`else
    chk("to_busy", bus.busy, 1);
    chk("to_err", bus.err, 0);
`endif
    repeat (3) cyc(0, 0, 0, 0);
    chk("to_rdy", bus.frame_rdy, 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
